// File: rtl/ram_pkg.sv
// ram_pkg: shared types and helpers for the parametrised single-port RAM.
//   state_e         : clear-sequencer state (CLEAR while zeroing, READY for traffic)
//   RDW_*           : read-during-write selector values for RDW_MODE
//   clog2_safe()    : address width helper that never returns 0
package ram_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_e;

   localparam int RDW_READ_FIRST  = 0;
   localparam int RDW_WRITE_FIRST = 1;

   // $clog2 yields 0 for depth<=1; a zero-width address bus is illegal.
   function automatic int clog2_safe(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// ram_clear_seq: post-reset clear sequencer. Walks a pointer over 0..DEPTH-1,
// requesting a zero write each cycle, then parks in READY until the next reset.
//   clk, rst_n      : clock, async active-low reset
//   busy_o          : high while clearing (port accesses must be ignored)
//   done_o          : high once the array is ready for traffic
//   clr_we_o        : write request for the array (zero data)
//   clr_addr_o      : address being cleared
module ram_clear_seq
   import ram_pkg::*;
#(
   parameter int DEPTH          = 4,
   parameter int ADDR_W         = clog2_safe(DEPTH),
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              busy_o,
   output logic              done_o,
   output logic              clr_we_o,
   output logic [ADDR_W-1:0] clr_addr_o
);

   localparam state_e      RST_STATE = CLEAR_ON_RESET ? CLEAR : READY;
   localparam [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RST_STATE;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      if (state_q == CLEAR) begin
         // Last word written this cycle: hand over to traffic next cycle.
         if (ptr_q == LAST_ADDR) state_d = READY;
         else                    ptr_d   = ptr_q + ADDR_W'(1);
      end
   end

   assign busy_o     = (state_q == CLEAR);
   assign done_o     = (state_q == READY);
   assign clr_we_o   = busy_o;
   assign clr_addr_o = ptr_q;

endmodule

// File: rtl/ram_sp_param.sv
// ram_sp_param: parametrised single-port synchronous RAM with registered read,
// valid strobe, selectable read-during-write, range check and post-reset clear.
//   clk, rst_n  : clock, async active-low reset
//   en, R_W     : access qualifier; R_W=1 write, 0 read
//   address     : word address (may exceed DEPTH-1 when DEPTH is not 2^n)
//   data_in     : write data
//   data_out    : registered read data
//   valid_out   : 1-cycle pulse, data_out updated by a read
//   busy        : clear sequence running; accesses ignored
//   addr_err    : 1-cycle pulse, accepted access was out of range
module ram_sp_param
   import ram_pkg::*;
#(
   parameter int DATA_W         = 4,
   parameter int DEPTH          = 4,
   parameter int ADDR_W         = clog2_safe(DEPTH),
   parameter int RDW_MODE       = RDW_READ_FIRST,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              R_W,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic              busy,
   output logic              addr_err
);

   logic              done, clr_we;
   logic [ADDR_W-1:0] clr_addr;

   ram_clear_seq #(
      .DEPTH          (DEPTH),
      .ADDR_W         (ADDR_W),
      .CLEAR_ON_RESET (CLEAR_ON_RESET)
   ) u_clr (
      .clk        (clk),
      .rst_n      (rst_n),
      .busy_o     (busy),
      .done_o     (done),
      .clr_we_o   (clr_we),
      .clr_addr_o (clr_addr)
   );

   // No reset on the array so it can map onto block RAM.
   logic [DATA_W-1:0] mem [DEPTH];

   logic              acc, in_range, we;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;

   assign acc      = done & en;
   assign in_range = (32'(address) < DEPTH);

   // Sequencer owns the write port while clearing; otherwise the user port does.
   assign we    = clr_we | (acc & R_W & in_range);
   assign waddr = clr_we ? clr_addr : address;
   assign wdata = clr_we ? '0 : data_in;

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d, err_q, err_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      data_d  = data_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      if (acc) begin
         err_d = ~in_range;
         if (R_W) begin
            if (RDW_MODE == RDW_WRITE_FIRST && in_range) data_d = data_in;
         end else begin
            // Out-of-range reads still complete, returning zero.
            valid_d = 1'b1;
            data_d  = in_range ? mem[address] : '0;
         end
      end
   end

   assign data_out  = data_q;
   assign valid_out = valid_q;
   assign addr_err  = err_q;

endmodule

// File: doc/ram_sp_param.md
Name: ram_sp_param

Overview:
- Parametrised single-port synchronous RAM; next generation of the fixed 4x4 RAM. Width and depth are configurable.
- Adds a registered read with a valid strobe, a selectable read-during-write mode, and address range checking.
- Adds a post-reset clear sequencer that zeroes the array before accepting traffic.
- Sits as a local scratch/storage block behind simple master logic in the same lab designs.

Parameters:
- DATA_W, 4, data word width in bits (>=1).
- DEPTH, 4, number of words (>=2; need not be a power of 2).
- ADDR_W, $clog2(DEPTH), address width.
- RDW_MODE, 0, read-during-write behaviour of data_out: 0 = read-first (old data), 1 = write-first (new data).
- CLEAR_ON_RESET, 1, 1 = zero the array after reset; 0 = skip the clear and go straight to ready.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  access request qualifier; no access when low.
- R_W  input  1  1 = write, 0 = read (sampled only when en=1).
- address  input  ADDR_W  word address.
- data_in  input  DATA_W  write data.
- data_out  output  DATA_W  registered read data.
- valid_out  output  1  1-cycle pulse: data_out updated by an accepted read.
- busy  output  1  high while the clear sequence runs; accesses are ignored.
- addr_err  output  1  1-cycle pulse: the accepted access had address >= DEPTH.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset (rst_n=0, immediate, no clock needed):
  - data_out=0, valid_out=0, addr_err=0.
  - FSM goes to CLEAR (clear pointer=0, busy=1) when CLEAR_ON_RESET=1; otherwise to READY (busy=0).
  - Array contents are not reset directly, so it can map to block RAM.
- FSM states:
  - CLEAR: each cycle writes 0 to mem[ptr], then ptr++. When ptr==DEPTH-1 is written, go to READY next cycle. busy=1 throughout, so the clear takes exactly DEPTH cycles after reset release. en/R_W are ignored, no valid_out, no addr_err.
  - READY: busy=0; accepts one access per cycle; stays in READY until reset.
- Accepted access: state READY and en=1 at the rising edge.
- Write (R_W=1, address<DEPTH):
  - mem[address] <= data_in at that edge.
  - RDW_MODE=0: data_out holds its previous value. RDW_MODE=1: data_out <= data_in.
  - valid_out stays 0 for writes in both modes.
- Read (R_W=0, address<DEPTH): data_out <= mem[address] at that edge. Latency 1: data is visible and valid_out=1 in the cycle after the request edge.
- Back-to-back reads: one per cycle, valid_out held high continuously.
- Write then read of the same address on the next cycle returns the new data (no hazard).
- Out-of-range (address>=DEPTH, only possible when DEPTH is not a power of 2):
  - Write: dropped.
  - Read: data_out <= 0 with valid_out=1.
  - Both: addr_err=1 for one cycle.
- en=0 in READY: data_out holds, valid_out=0, addr_err=0.
- Reset asserted mid-clear or mid-traffic: abort immediately and restart the full clear on release. A read in flight is lost (valid_out forced to 0).

Decomposition:
- Package ram_pkg:
  - state enum {CLEAR, READY}.
  - RDW_READ_FIRST=0 and RDW_WRITE_FIRST=1 constants.
  - Function clog2_safe(DEPTH), which returns >=1.
- Sub-module ram_clear_seq: owns the pointer, busy and done; the top muxes write address/data/enable between the sequencer and the port.
- Array, read register and error logic stay in the top.

Test Plan:
- Clear: DATA_W=4, DEPTH=4, preload mem with 4'hF via backdoor, pulse rst_n low -> busy=1 for exactly 4 cycles after release; reads of addresses 0..3 return 0 with valid_out pulses.
- Write/read sweep: write 15,12,10,9 to addresses 0..3, then read 0..3 back-to-back -> data_out 15,12,10,9 on consecutive cycles, one cycle after each request, valid_out high for 4 cycles.
- RDW mode: RDW_MODE=0, mem[1]=12, write 7 to address 1 -> data_out unchanged. Repeat with RDW_MODE=1 -> data_out=7 the next cycle, valid_out=0 in both runs.
- Range check: DEPTH=5, ADDR_W=3:
  - Write 6 to address 6 -> addr_err pulse, no array change.
  - Read address 7 -> data_out=0, valid_out=1, addr_err=1.
- Busy masking: issue write 9 to address 2 during CLEAR -> ignored; after ready, read address 2 returns 0.
- Reset mid-operation: drop rst_n during a read cycle and during clear cycle 2 -> outputs 0 immediately; a full DEPTH-cycle clear repeats on release.
